// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults and types for the I2S codec port
package i2s_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int SLOT_BITS_DEF = 32;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_t;

  typedef enum logic {CH_LEFT, CH_RIGHT} ch_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// rtl/i2s_clk_gen.sv - BCLK/LRCK generator with bit-slot position tracking
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   en           link enable; low forces the idle bus state
//   bclk, lrck   bit clock and word select (0 = left, 1 = right)
//   rise_evt     BCLK 0->1 toggles on this clock
//   fall_evt     BCLK 1->0 toggles on this clock
//   frame_start  fall event where LRCK goes 1->0
//   right_start  fall event where LRCK goes 0->1
//   p, ch        slot position and channel: updated values on a fall event,
//                current values otherwise (so a rise samples the bit driven
//                at the preceding fall)
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int CLK_DIV   = 2,
  parameter int PW        = $clog2(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          bclk,
  output logic          lrck,
  output logic          rise_evt,
  output logic          fall_evt,
  output logic          frame_start,
  output logic          right_start,
  output logic [PW-1:0] p,
  output ch_e           ch
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BIT_LAST = PW'(SLOT_BITS - 1);

  logic [DW-1:0] div_cnt;
  logic [PW-1:0] bit_cnt;
  logic          tick;
  logic          slot_wrap;

  assign tick        = en && (div_cnt == DIV_LAST);
  assign rise_evt    = tick && !bclk;
  assign fall_evt    = tick && bclk;
  assign slot_wrap   = fall_evt && (bit_cnt == BIT_LAST);
  assign frame_start = slot_wrap && lrck;
  assign right_start = slot_wrap && !lrck;

  // Look-ahead of the slot position so the top can act in the same clock
  // as the BCLK falling toggle.
  always_comb begin
    p  = bit_cnt;
    ch = lrck ? CH_RIGHT : CH_LEFT;
    if (fall_evt) begin
      p = slot_wrap ? '0 : bit_cnt + 1'b1;
      if (slot_wrap) begin
        ch = lrck ? CH_LEFT : CH_RIGHT;
      end
    end
  end

  // Idle state doubles as the pre-frame state: bit_cnt at its last value and
  // LRCK high make the first fall event after enable a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= BIT_LAST;
      bclk    <= 1'b0;
      lrck    <= 1'b1;
    end else if (!en) begin
      div_cnt <= '0;
      bit_cnt <= BIT_LAST;
      bclk    <= 1'b0;
      lrck    <= 1'b1;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_evt) begin
        bit_cnt <= p;
        if (slot_wrap) begin
          lrck <= ~lrck;
        end
      end
    end
  end

endmodule

// File: rtl/i2s_codec_port.sv
// rtl/i2s_codec_port.sv - I2S bus master: ADC sample serializer and DAC deserializer
//
// Ports:
//   i_clk, i_rst             system clock, asynchronous active-high reset
//   i_en                     link enable; low idles the bus
//   i_tx_left/right/valid    stereo ADC pair offered; o_tx_ready = buffer empty
//   o_bclk, o_lrck           bit clock and word select (0 = left)
//   o_adcdat                 serial ADC data, MSB first, one BCLK after LRCK edge
//   i_dacdat                 serial DAC data sampled on BCLK rise
//   o_rx_left/right/valid    last complete received pair, valid pulses once
//   o_underrun               pulse when a frame starts with no pair buffered
module i2s_codec_port
  import i2s_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF,
  parameter int CLK_DIV   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_tx_left,
  input  logic [DATA_W-1:0] i_tx_right,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_bclk,
  output logic              o_lrck,
  output logic              o_adcdat,
  input  logic              i_dacdat,
  output logic [DATA_W-1:0] o_rx_left,
  output logic [DATA_W-1:0] o_rx_right,
  output logic              o_rx_valid,
  output logic              o_underrun
);

  localparam int PW = $clog2(SLOT_BITS);
  localparam logic [PW-1:0] P_LAST = PW'(DATA_W);

  logic          rise_evt;
  logic          fall_evt;
  logic          frame_start;
  logic          right_start;
  logic [PW-1:0] p;
  ch_e           ch;

  i2s_clk_gen #(
    .SLOT_BITS (SLOT_BITS),
    .CLK_DIV   (CLK_DIV),
    .PW        (PW)
  ) u_clk_gen (
    .clk         (i_clk),
    .rst         (i_rst),
    .en          (i_en),
    .bclk        (o_bclk),
    .lrck        (o_lrck),
    .rise_evt    (rise_evt),
    .fall_evt    (fall_evt),
    .frame_start (frame_start),
    .right_start (right_start),
    .p           (p),
    .ch          (ch)
  );

  logic              buf_full;
  logic [DATA_W-1:0] buf_l;
  logic [DATA_W-1:0] buf_r;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_hold_l;
  logic [DATA_W-1:0] rx_word;
  logic              left_ok;
  logic              in_data;

  assign in_data    = (p != '0) && (p <= P_LAST);
  assign rx_word    = {rx_shift, i_dacdat};
  assign o_tx_ready = !buf_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_full   <= 1'b0;
      buf_l      <= '0;
      buf_r      <= '0;
      hold_r     <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_hold_l  <= '0;
      left_ok    <= 1'b0;
      o_adcdat   <= 1'b0;
      o_rx_left  <= '0;
      o_rx_right <= '0;
      o_rx_valid <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_underrun <= 1'b0;

      // Capture uses the pre-edge buffer state, so a frame start in the same
      // clock still sees the old contents.
      if (i_tx_valid && !buf_full) begin
        buf_l    <= i_tx_left;
        buf_r    <= i_tx_right;
        buf_full <= 1'b1;
      end

      if (!i_en) begin
        o_adcdat <= 1'b0;
        left_ok  <= 1'b0;
      end else begin
        if (fall_evt) begin
          o_adcdat <= in_data ? tx_shift[DATA_W-1] : 1'b0;
          if (frame_start) begin
            if (buf_full) begin
              tx_shift <= buf_l;
              hold_r   <= buf_r;
              buf_full <= 1'b0;
            end else begin
              tx_shift   <= '0;
              hold_r     <= '0;
              o_underrun <= 1'b1;
            end
          end else if (right_start) begin
            tx_shift <= hold_r;
          end else if (in_data) begin
            tx_shift <= tx_shift << 1;
          end
        end

        if (rise_evt && in_data) begin
          rx_shift <= rx_word[DATA_W-2:0];
          if (p == P_LAST) begin
            if (ch == CH_LEFT) begin
              rx_hold_l <= rx_word;
              left_ok   <= 1'b1;
            end else if (left_ok) begin
              o_rx_left  <= rx_hold_l;
              o_rx_right <= rx_word;
              o_rx_valid <= 1'b1;
              left_ok    <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule
